screen_sequencer: RTL

Top-level screen controller that decides which full-screen drawer (title, in-game, game-over) owns the VGA colour outputs. A three-state machine changes screens only at frame boundaries so a frame never tears. It also holds the game logic in reset whenever play is not active. It sits between the per-screen drawers and the VGA pins, and shares the same `row`/`column`/`display_enable` timing.

---
 rtl/screen_pkg.sv | 18 +
 rtl/button_edge_detector.sv | 27 ++
 rtl/screen_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// Shared types and widths for the screen sequencer slice.
package screen_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    SCR_TITLE = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_OVER  = 2'd2
  } screen_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/button_edge_detector.sv
// Two-flop synchroniser for an asynchronous button plus a one-cycle rising-edge pulse.
module button_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pulse
);

  logic sync_meta;
  logic sync_q;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  assign pulse = sync_q & ~sync_prev;

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous TITLE/PLAY/OVER screen selector driving the VGA colour pins.
// Define SCREEN_AUTO_RETURN_EN to let OVER fall back to TITLE after TIMEOUT_FRAMES.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int HOLD_FRAMES    = 120,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic        vga_clock,
  input  logic        reset,
  input  logic        jump_button,
  input  logic        player_dead,
  input  logic        level_complete,
  input  logic [31:0] row,
  input  logic [31:0] column,
  input  logic        display_enable,
  input  logic [11:0] title_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] over_rgb,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic [1:0]  screen,
  output logic        game_reset,
  output logic [9:0]  leds
);

  screen_t                state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   press_pend_q, dead_pend_q, clear_pend_q;
  logic                   press_edge;
  logic                   frame_tick;
  rgb12_t                 rgb_sel, rgb_q;

  // Geometry/timeout values not consumed by every build configuration.
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(SCREEN_WIDTH) ^ 32'(TIMEOUT_FRAMES);

  button_edge_detector u_jump_edge (
    .clk    (vga_clock),
    .rst_n  (reset),
    .button (jump_button),
    .pulse  (press_edge)
  );

  assign frame_tick = (row == 32'(SCREEN_HEIGHT)) && (column == '0);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      SCR_TITLE: begin
        if (press_pend_q) state_d = SCR_PLAY;
      end
      SCR_PLAY: begin
        if (dead_pend_q)       state_d = SCR_OVER;
        else if (clear_pend_q) state_d = SCR_TITLE;
      end
      SCR_OVER: begin
        if (press_pend_q && (frame_cnt_q >= FRAME_CNT_W'(HOLD_FRAMES))) state_d = SCR_TITLE;
`ifdef SCREEN_AUTO_RETURN_EN
        if (frame_cnt_q == FRAME_CNT_W'(TIMEOUT_FRAMES - 1)) state_d = SCR_TITLE;
`endif
        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
      end
      default: state_d = SCR_TITLE;
    endcase
    if (state_d != state_q) frame_cnt_d = '0;
  end

  // Pending flags are dropped at every boundary, including pulses landing on the tick itself.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= SCR_TITLE;
      frame_cnt_q  <= '0;
      press_pend_q <= 1'b0;
      dead_pend_q  <= 1'b0;
      clear_pend_q <= 1'b0;
    end else if (frame_tick) begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      press_pend_q <= 1'b0;
      dead_pend_q  <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      if (press_edge)     press_pend_q <= 1'b1;
      if (player_dead)    dead_pend_q  <= 1'b1;
      if (level_complete) clear_pend_q <= 1'b1;
    end
  end

  always_comb begin
    rgb_sel = '0;
    case (state_q)
      SCR_TITLE: rgb_sel = rgb12_t'(title_rgb);
      SCR_PLAY:  rgb_sel = rgb12_t'(game_rgb);
      SCR_OVER:  rgb_sel = rgb12_t'(over_rgb);
      default:   rgb_sel = '0;
    endcase
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) rgb_q <= '0;
    else        rgb_q <= display_enable ? rgb_sel : '0;
  end

  assign vga_red    = rgb_q.r;
  assign vga_green  = rgb_q.g;
  assign vga_blue   = rgb_q.b;
  assign screen     = state_q;
  assign game_reset = (state_q != SCR_PLAY);
  assign leds       = {frame_cnt_q[4:0], clear_pend_q, dead_pend_q, press_pend_q, state_q};

endmodule
